// File: rtl/mutual_pair_sequencer.sv
// mutual_pair_sequencer: walks the W&A mutual mask of a held block, emitting up to MAX_NUM_OUTPUT matched pairs per beat
module mutual_pair_sequencer #(
   parameter int BITMASK_LENGTH = 8,
   parameter int VALUE_WIDTH    = 8,
   parameter int MAX_NUM_OUTPUT = 2,
   parameter int INDEX_BITWIDTH = 4,
   parameter int COUNT_BITWIDTH = 2
) (
   input  logic                                   clock,
   input  logic                                   resetn,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [BITMASK_LENGTH-1:0]              in_bitmask_w,
   input  logic [BITMASK_LENGTH-1:0]              in_bitmask_a,
   input  logic [VALUE_WIDTH*BITMASK_LENGTH-1:0]  in_values_w,
   input  logic [VALUE_WIDTH*BITMASK_LENGTH-1:0]  in_values_a,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [VALUE_WIDTH*MAX_NUM_OUTPUT-1:0]  out_w,
   output logic [VALUE_WIDTH*MAX_NUM_OUTPUT-1:0]  out_a,
   output logic [COUNT_BITWIDTH-1:0]              out_count,
   output logic                                   out_last
);
   logic [VALUE_WIDTH*BITMASK_LENGTH-1:0] r_vals_w, r_vals_a;
   logic [BITMASK_LENGTH-1:0]             r_mask;
   logic                                  r_have;
   logic [INDEX_BITWIDTH-1:0]             r_idx;
   logic                                  r_out_valid, r_out_last;
   logic [VALUE_WIDTH*MAX_NUM_OUTPUT-1:0] r_out_w, r_out_a;
   logic [COUNT_BITWIDTH-1:0]             r_out_count;
   logic [BITMASK_LENGTH-1:0]             w_left;
   logic [VALUE_WIDTH*MAX_NUM_OUTPUT-1:0] w_lane_w, w_lane_a;
   logic [COUNT_BITWIDTH-1:0]             w_cnt;
   logic [INDEX_BITWIDTH-1:0]             w_next_idx;
   logic                                  w_last, w_load, w_accept;
   int                                    w_pos;

   // Pick the lowest matched positions at or above idx; whatever stays in w_left decides last
   always_comb begin
      w_left     = '0;
      w_lane_w   = '0;
      w_lane_a   = '0;
      w_cnt      = '0;
      w_pos      = 0;
      w_next_idx = INDEX_BITWIDTH'(BITMASK_LENGTH);
      for (int i = 0; i < BITMASK_LENGTH; i++) w_left[i] = r_mask[i] && (i >= int'(r_idx));
      for (int k = 0; k < MAX_NUM_OUTPUT; k++) begin
         w_pos = BITMASK_LENGTH;
         for (int i = BITMASK_LENGTH - 1; i >= 0; i--) if (w_left[i]) w_pos = i;
         if (w_pos < BITMASK_LENGTH) begin
            w_lane_w[k*VALUE_WIDTH +: VALUE_WIDTH] = r_vals_w[w_pos*VALUE_WIDTH +: VALUE_WIDTH];
            w_lane_a[k*VALUE_WIDTH +: VALUE_WIDTH] = r_vals_a[w_pos*VALUE_WIDTH +: VALUE_WIDTH];
            w_left[w_pos] = 1'b0;
            w_cnt         = w_cnt + COUNT_BITWIDTH'(1);
            w_next_idx    = INDEX_BITWIDTH'(w_pos + 1);
         end
      end
      w_last = (w_left == '0);
   end

   assign w_load    = r_have & (~r_out_valid | out_ready);
   assign in_ready  = ~r_have | (w_load & w_last);
   assign w_accept  = in_valid & in_ready;
   assign out_valid = r_out_valid;
   assign out_w     = r_out_w;
   assign out_a     = r_out_a;
   assign out_count = r_out_count;
   assign out_last  = r_out_last;

   // Beat register and held block; a same-cycle accept overrides the have_blk clear of the last beat
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_vals_w    <= '0;
         r_vals_a    <= '0;
         r_mask      <= '0;
         r_have      <= 1'b0;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_out_w     <= '0;
         r_out_a     <= '0;
         r_out_count <= '0;
         r_out_last  <= 1'b0;
      end else begin
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_w     <= w_lane_w;
            r_out_a     <= w_lane_a;
            r_out_count <= w_cnt;
            r_out_last  <= w_last;
            r_idx       <= w_next_idx;
            if (w_last) r_have <= 1'b0;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_accept) begin
            r_vals_w <= in_values_w;
            r_vals_a <= in_values_a;
            r_mask   <= in_bitmask_w & in_bitmask_a;
            r_idx    <= '0;
            r_have   <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mutual_pair_sequencer.sv
// tb_mutual_pair_sequencer: scenario tasks against a list-of-matches scoreboard model
module tb_mutual_pair_sequencer;
   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_bitmask_w = '0, in_bitmask_a = '0;
   logic [63:0] in_values_w = '0, in_values_a = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_w, out_a;
   logic [1:0]  out_count;
   logic        out_last;

   int n_pass = 0, n_total = 0;
   logic [15:0] q_w[$], q_a[$];
   logic [1:0]  q_c[$];
   logic        q_l[$];
   logic        h_valid = 1'b0, h_l;
   logic [15:0] h_w, h_a;
   logic [1:0]  h_c;

   mutual_pair_sequencer dut (
      .clock(clock), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_bitmask_w(in_bitmask_w), .in_bitmask_a(in_bitmask_a),
      .in_values_w(in_values_w), .in_values_a(in_values_a),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_w(out_w), .out_a(out_a), .out_count(out_count), .out_last(out_last)
   );

   initial forever #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
      $fatal(1);
   end

   function automatic logic [63:0] rand64();
      return {$urandom(), $urandom()};
   endfunction

   // Model: list the matched positions, then chop that list into beats of two
   task automatic push_block(input logic [7:0] bw, input logic [7:0] ba, input logic [63:0] vw, input logic [63:0] va);
      int pos[$];
      int nb;
      for (int i = 0; i < 8; i++) if (bw[i] && ba[i]) pos.push_back(i);
      nb = (pos.size() + 1) / 2;
      if (nb == 0) nb = 1;
      for (int b = 0; b < nb; b++) begin
         logic [15:0] ew = '0, ea = '0;
         int c = 0;
         for (int l = 0; l < 2; l++) begin
            int j = 2 * b + l;
            if (j < pos.size()) begin
               ew[l*8 +: 8] = vw[pos[j]*8 +: 8];
               ea[l*8 +: 8] = va[pos[j]*8 +: 8];
               c++;
            end
         end
         q_w.push_back(ew);
         q_a.push_back(ea);
         q_c.push_back(2'(c));
         q_l.push_back(b == nb - 1);
      end
   endtask

   // One clock of stimulus; scores any consumed beat and checks stability of a stalled beat
   task automatic step(input logic v, input logic [7:0] bw, input logic [7:0] ba, input logic [63:0] vw,
                       input logic [63:0] va, input logic rdy, output logic acc, output logic fire);
      @(negedge clock);
      in_valid = v; in_bitmask_w = bw; in_bitmask_a = ba; in_values_w = vw; in_values_a = va; out_ready = rdy;
      #1;
      acc  = in_valid & in_ready;
      fire = out_valid & out_ready;
      if (h_valid) begin
         n_total++;
         if ({out_valid, out_w, out_a, out_count, out_last} !== {1'b1, h_w, h_a, h_c, h_l})
            $display("FAIL hold: got v=%b w=%h a=%h c=%0d l=%b exp v=1 w=%h a=%h c=%0d l=%b",
                     out_valid, out_w, out_a, out_count, out_last, h_w, h_a, h_c, h_l);
         else n_pass++;
      end
      if (fire) begin
         n_total++;
         if (q_w.size() == 0) $display("FAIL extra_beat: got w=%h a=%h c=%0d l=%b exp no beat", out_w, out_a, out_count, out_last);
         else begin
            if (out_w !== q_w[0] || out_a !== q_a[0] || out_count !== q_c[0] || out_last !== q_l[0])
               $display("FAIL beat: got w=%h a=%h c=%0d l=%b exp w=%h a=%h c=%0d l=%b",
                        out_w, out_a, out_count, out_last, q_w[0], q_a[0], q_c[0], q_l[0]);
            else n_pass++;
            void'(q_w.pop_front()); void'(q_a.pop_front()); void'(q_c.pop_front()); void'(q_l.pop_front());
         end
      end
      h_valid = out_valid & ~out_ready;
      h_w = out_w; h_a = out_a; h_c = out_count; h_l = out_last;
      if (acc) push_block(bw, ba, vw, va);
   endtask

   task automatic send(input logic [7:0] bw, input logic [7:0] ba, input logic [63:0] vw, input logic [63:0] va, input logic rdy);
      logic acc = 1'b0, fire;
      for (int c = 0; c < 50 && !acc; c++) step(1'b1, bw, ba, vw, va, rdy, acc, fire);
      n_total++;
      if (!acc) $display("FAIL accept: got in_ready never high exp accept within 50 cycles");
      else n_pass++;
   endtask

   task automatic drain();
      logic acc, fire;
      for (int c = 0; c < 60 && (q_w.size() != 0 || out_valid); c++) step(1'b0, '0, '0, '0, '0, 1'b1, acc, fire);
      n_total++;
      if (q_w.size() != 0 || out_valid !== 1'b0) $display("FAIL drain: got %0d beats pending out_valid=%b exp 0 and 0", q_w.size(), out_valid);
      else n_pass++;
   endtask

   task automatic test_reset();
      n_total++;
      if ({in_ready, out_valid, out_w, out_a, out_count, out_last} !== {1'b1, 1'b0, 16'h0, 16'h0, 2'd0, 1'b0})
         $display("FAIL reset: got rdy=%b v=%b w=%h a=%h c=%0d l=%b exp rdy=1 all else 0",
                  in_ready, out_valid, out_w, out_a, out_count, out_last);
      else n_pass++;
   endtask

   task automatic test_pairs();
      send(8'b1011_0110, 8'b1110_0011, rand64(), rand64(), 1'b1);
      drain();
   endtask

   task automatic test_empty();
      logic acc, fire;
      send(8'h0F, 8'hF0, rand64(), rand64(), 1'b1);
      drain();
      step(1'b0, '0, '0, '0, '0, 1'b1, acc, fire);
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL empty_ready: got %b exp 1", in_ready);
      else n_pass++;
   endtask

   task automatic test_full();
      send(8'hFF, 8'hFF, rand64(), rand64(), 1'b1);
      drain();
   endtask

   task automatic test_backpressure();
      logic acc, fire;
      int stalls = 0;
      send(8'b1011_0110, 8'b1110_0011, rand64(), rand64(), 1'b0);
      for (int c = 0; c < 20 && stalls < 3; c++) begin
         step(1'b0, '0, '0, '0, '0, 1'b0, acc, fire);
         if (out_valid) stalls++;
      end
      n_total++;
      if (stalls != 3) $display("FAIL stall: got %0d stalled cycles exp 3", stalls);
      else n_pass++;
      drain();
   endtask

   task automatic test_back_to_back();
      logic acc = 1'b0, fire;
      logic [63:0] vw = rand64(), va = rand64();
      int waited = 0;
      send(8'b1011_0110, 8'b1110_0011, rand64(), rand64(), 1'b1);
      for (int c = 0; c < 20 && !acc; c++) begin
         step(1'b1, 8'hFF, 8'hFF, vw, va, 1'b1, acc, fire);
         waited++;
      end
      n_total++;
      if (waited != 2 || out_valid !== 1'b1 || out_last !== 1'b0)
         $display("FAIL b2b_accept: got wait=%0d v=%b l=%b exp wait=2 v=1 l=0", waited, out_valid, out_last);
      else n_pass++;
      for (int c = 0; c < 5; c++) begin
         step(1'b0, '0, '0, '0, '0, 1'b1, acc, fire);
         n_total++;
         if (out_valid !== 1'b1) $display("FAIL b2b_bubble: got out_valid=%b at beat %0d exp 1", out_valid, c + 2);
         else n_pass++;
      end
      drain();
   endtask

   task automatic test_reset_mid();
      logic acc, fire = 1'b0;
      send(8'hFF, 8'hFF, rand64(), rand64(), 1'b1);
      for (int c = 0; c < 10 && !fire; c++) step(1'b0, '0, '0, '0, '0, 1'b1, acc, fire);
      @(negedge clock);
      #2 resetn = 1'b0;
      #1;
      n_total++;
      if ({in_ready, out_valid, out_w, out_a, out_count, out_last} !== {1'b1, 1'b0, 16'h0, 16'h0, 2'd0, 1'b0})
         $display("FAIL reset_mid: got rdy=%b v=%b w=%h a=%h c=%0d l=%b exp rdy=1 all else 0",
                  in_ready, out_valid, out_w, out_a, out_count, out_last);
      else n_pass++;
      q_w.delete(); q_a.delete(); q_c.delete(); q_l.delete();
      h_valid = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      send(8'b1011_0110, 8'b1110_0011, rand64(), rand64(), 1'b1);
      drain();
   endtask

   task automatic test_random();
      logic acc, fire;
      for (int n = 0; n < 400; n++) begin
         logic [7:0] bw = 8'($urandom()), ba = 8'($urandom());
         case ($urandom_range(0, 3))
            0: ba = ~bw;
            1: begin bw = 8'hFF; ba = 8'hFF; end
            2: ba = ba & 8'($urandom());
            default: ;
         endcase
         step($urandom_range(0, 3) != 0, bw, ba, rand64(), rand64(), $urandom_range(0, 2) != 0, acc, fire);
      end
      drain();
   endtask

   initial begin
      #12 resetn = 1'b1;
      test_reset();
      test_pairs();
      test_empty();
      test_full();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/mutual_pair_sequencer.md
# mutual_pair_sequencer

Sequential front end for the sparse MAC datapath. It accepts one transfer block per handshake: a weight (W) and an activation (A) bitmask, each with BITMASK_LENGTH uncompressed value lanes. It walks the mutual mask (W & A) from a running start index and emits up to MAX_NUM_OUTPUT matched W/A operand pairs per beat to the MAC buffer-update stage. It is the registered, back-pressured replacement for driving the combinational mask matcher one startIndex at a time from software.

## Interface
- BITMASK_LENGTH, 8, positions per transfer block
- VALUE_WIDTH, 8, bits per W or A value
- MAX_NUM_OUTPUT, 2, pairs per output beat (fixed at 2 for this revision)
- INDEX_BITWIDTH, 4, start-index width, floor(log2(BITMASK_LENGTH))+1
- COUNT_BITWIDTH, 2, width of out_count
- clock  in  1  single clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  transfer block present
- in_ready  out  1  block accepted on in_valid & in_ready
- in_bitmask_w  in  BITMASK_LENGTH  W nonzero mask, bit i = position i
- in_bitmask_a  in  BITMASK_LENGTH  A nonzero mask
- in_values_w  in  VALUE_WIDTH*BITMASK_LENGTH  W lane i at [(i+1)*VALUE_WIDTH-1 -: VALUE_WIDTH]
- in_values_a  in  VALUE_WIDTH*BITMASK_LENGTH  A lanes, same packing
- out_valid  out  1  beat present
- out_ready  in  1  beat consumed on out_valid & out_ready
- out_w  out  VALUE_WIDTH*MAX_NUM_OUTPUT  matched W values, lane 0 = lowest position
- out_a  out  VALUE_WIDTH*MAX_NUM_OUTPUT  matched A values, same lane order
- out_count  out  COUNT_BITWIDTH  valid lanes in beat (0..MAX_NUM_OUTPUT)
- out_last  out  1  final beat of current block

## Operation
- Held-block registers: W and A values, mutual mask M = in_bitmask_w & in_bitmask_a, have_blk flag, idx (INDEX_BITWIDTH).
- On accept: latch values and M, set idx=0, set have_blk=1.
- Beat generation: the output register loads when have_blk & (!out_valid | out_ready).
  - Find the lowest set bits of M at positions >= idx, up to MAX_NUM_OUTPUT of them: p0 < p1.
  - Lane k gets W[pk] and A[pk]. Unfilled lanes are driven to zero.
  - out_count = number of positions found.
  - next idx = p_last+1.
  - out_last = 1 iff M has no set bit at positions >= next idx.
- Empty mutual mask (M==0): exactly one beat, out_count=0, out_last=1, data zero. Downstream counts blocks by out_last.
- Beats per block = max(1, ceil(popcount(M)/2)). idx never exceeds BITMASK_LENGTH, and no wrap-around occurs.
- When the last beat loads: have_blk clears, unless a new block is accepted in the same cycle. In that case the new block is latched and idx=0.
- in_ready = !have_blk | (load this cycle & beat being loaded is last). This is combinational from state, out_valid and out_ready; there is no combinational in_valid->in_ready path.
- out_valid clears on out_ready with no load pending.

## Timing
- Reset: in_ready=1 after reset; out_valid=0, out_w=0, out_a=0, out_count=0, out_last=0, have_blk=0, idx=0.
- Latency: block accepted at edge k produces its first beat with out_valid=1 after edge k+1.
- Throughput: one beat per cycle while out_ready=1. Consecutive blocks have zero bubbles.
- Back-pressure: while out_valid & !out_ready, all out_* hold stable and idx does not advance.
- Simultaneous final-beat load and new-block accept: the new block's first beat follows on the next edge.
- Asserting resetn low mid-block discards the held block and any pending beat. It does not emit a partial out_last.
- in_* are sampled only on accept; changes while in_ready=0 are ignored.

## Test plan
- W=8'b1011_0110, A=8'b1110_0011 (M=8'b1010_0010), out_ready=1:
  - beat 1: lanes (W1,A1),(W5,A5), count=2, last=0
  - beat 2: lane (W7,A7), lane1=0, count=1, last=1
- W=8'h0F, A=8'hF0: exactly one beat, count=0, last=1, out_w=out_a=0; in_ready=1 the following cycle.
- W=A=8'hFF: four beats with pairs (0,1),(2,3),(4,5),(6,7); last only on beat 4.
- Same block as the first scenario, with out_ready low for 3 cycles on beat 1: beat 1 held bit-exact, then beat 2 follows. Exactly 2 beats in total.
- Two blocks presented back-to-back with in_valid held: the second is accepted in the cycle beat 2 of the first loads, and its first beat appears the next cycle with no idle cycle.
- Assert resetn mid-block after beat 1: all outputs return to reset values; a new block afterwards yields correct beats starting from idx 0.
